// File: rtl/cache_mem_if.sv
// ---------------------------------------------------------------------------
// cache_mem_if
// Signal bundle between a cache controller, the cache_mem port block and the
// 32-bit main-memory bus.
//
//   Controller side : mem_begin, writeback, req_tag, req_index, req_data  (to port)
//                     mem_wait, mem_end, mem_read_end, mem_tag, mem_index,
//                     mem_readdata                                         (from port)
//   Bus side        : bus_address, bus_read, bus_write, bus_writedata     (from port)
//                     bus_readdata, bus_waitrequest                        (to port)
//
// Handshakes:
//   - Controller: mem_begin is taken at a clock edge where mem_wait=0; while
//     mem_wait=1 the strobe is ignored and the controller must retry.
//     Completion is a one-cycle mem_end pulse (plus mem_read_end for refills).
//   - Bus: a beat transfers at an edge where (bus_read|bus_write)=1 and
//     bus_waitrequest=0; until then address/data are held stable.
//
// Modports: slave = the cache_mem block, master = controller/interconnect.
// ---------------------------------------------------------------------------
interface cache_mem_if #(
  parameter int TAG_BITS   = 16,
  parameter int INDEX_BITS = 12
);
  logic                  mem_begin;
  logic                  writeback;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_index;
  logic [127:0]          req_data;
  logic                  mem_wait;
  logic                  mem_end;
  logic                  mem_read_end;
  logic [TAG_BITS-1:0]   mem_tag;
  logic [INDEX_BITS-1:0] mem_index;
  logic [127:0]          mem_readdata;
  logic [31:0]           bus_address;
  logic                  bus_read;
  logic                  bus_write;
  logic [31:0]           bus_writedata;
  logic [31:0]           bus_readdata;
  logic                  bus_waitrequest;

  modport slave (
    input  mem_begin, writeback, req_tag, req_index, req_data,
    input  bus_readdata, bus_waitrequest,
    output mem_wait, mem_end, mem_read_end, mem_tag, mem_index, mem_readdata,
    output bus_address, bus_read, bus_write, bus_writedata
  );

  modport master (
    output mem_begin, writeback, req_tag, req_index, req_data,
    output bus_readdata, bus_waitrequest,
    input  mem_wait, mem_end, mem_read_end, mem_tag, mem_index, mem_readdata,
    input  bus_address, bus_read, bus_write, bus_writedata
  );
endinterface

// File: rtl/cache_mem.sv
// ---------------------------------------------------------------------------
// cache_mem
// Memory-side port of one cache node. Turns a line refill or writeback
// request into four sequential 32-bit bus beats, reassembling refill data
// into a 128-bit line returned with its tag and index.
//
// Ports:
//   clk         : clock
//   rst_n       : synchronous active-low reset
//   io_mem      : cache_mem_if.slave (controller request/response + bus)
//   o_dbg_state : current FSM state (0 IDLE, 1 READ, 2 WRITE)
//
// TAG_BITS + INDEX_BITS + 4 must equal 32; the bus address concatenation
// below only lines up with the 32-bit bus under that condition.
// ---------------------------------------------------------------------------
module cache_mem #(
  parameter int TAG_BITS   = 16,
  parameter int INDEX_BITS = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  cache_mem_if.slave        io_mem,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  state_e                r_state, w_state_nxt;
  logic [1:0]            r_cnt, w_cnt_nxt;
  logic [TAG_BITS-1:0]   r_tag, w_tag_nxt;
  logic [INDEX_BITS-1:0] r_index, w_index_nxt;
  logic [127:0]          r_wdata, w_wdata_nxt;
  logic [95:0]           r_line;           // words 0..2; word 3 goes straight to the output
  logic                  w_start, w_accept, w_last;

  logic                  r_end, r_read_end;
  logic [TAG_BITS-1:0]   r_mem_tag;
  logic [INDEX_BITS-1:0] r_mem_index;
  logic [127:0]          r_mem_readdata;
  logic [31:0]           r_bus_address, r_bus_writedata;
  logic                  r_bus_read, r_bus_write;

  assign w_start  = (r_state == ST_IDLE) && io_mem.mem_begin;
  assign w_accept = (r_bus_read || r_bus_write) && !io_mem.bus_waitrequest;
  assign w_last   = w_accept && (r_cnt == 2'd3);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and next request/counter values
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tag_nxt   = r_tag;
    w_index_nxt = r_index;
    w_wdata_nxt = r_wdata;
    case (r_state)
      ST_IDLE: begin
        if (io_mem.mem_begin) begin
          w_state_nxt = io_mem.writeback ? ST_WRITE : ST_READ;
          w_cnt_nxt   = 2'd0;
          w_tag_nxt   = io_mem.req_tag;
          w_index_nxt = io_mem.req_index;
          w_wdata_nxt = io_mem.req_data;
        end
      end
      ST_READ, ST_WRITE: begin
        // The counter only reaches 3->0 on the final beat, which also ends the transfer.
        if (w_accept) w_cnt_nxt = r_cnt + 2'd1;
        if (w_last)   w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Combinational outputs
  always_comb begin
    io_mem.mem_wait = (r_state != ST_IDLE);
    o_dbg_state     = r_state;
  end

  // Request latch, beat counter and read line buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= 2'd0;
      r_tag   <= '0;
      r_index <= '0;
      r_wdata <= '0;
      r_line  <= '0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_tag   <= w_tag_nxt;
      r_index <= w_index_nxt;
      r_wdata <= w_wdata_nxt;
      if (r_bus_read && w_accept) begin
        case (r_cnt)
          2'd0:    r_line[31:0]  <= io_mem.bus_readdata;
          2'd1:    r_line[63:32] <= io_mem.bus_readdata;
          2'd2:    r_line[95:64] <= io_mem.bus_readdata;
          default: ;
        endcase
      end
    end
  end

  // Registered bus outputs: computed from next state so a beat's address and
  // data are already on the bus in the cycle after the request or previous
  // beat, and are simply re-registered unchanged while waitrequest stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bus_read      <= 1'b0;
      r_bus_write     <= 1'b0;
      r_bus_address   <= '0;
      r_bus_writedata <= '0;
    end else begin
      r_bus_read      <= (w_state_nxt == ST_READ);
      r_bus_write     <= (w_state_nxt == ST_WRITE);
      r_bus_address   <= (w_state_nxt == ST_IDLE) ? 32'd0
                       : {w_tag_nxt, w_index_nxt, w_cnt_nxt, 2'b00};
      r_bus_writedata <= (w_state_nxt == ST_WRITE) ? w_wdata_nxt[{w_cnt_nxt, 5'd0} +: 32]
                       : 32'd0;
    end
  end

  // Completion pulses and refill result. The result registers only load on
  // refill completion so they stay stable across intervening writebacks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_end          <= 1'b0;
      r_read_end     <= 1'b0;
      r_mem_tag      <= '0;
      r_mem_index    <= '0;
      r_mem_readdata <= '0;
    end else begin
      r_end      <= w_last;
      r_read_end <= w_last && r_bus_read;
      if (w_last && r_bus_read) begin
        r_mem_tag      <= r_tag;
        r_mem_index    <= r_index;
        r_mem_readdata <= {io_mem.bus_readdata, r_line};
      end
    end
  end

  assign io_mem.mem_end       = r_end;
  assign io_mem.mem_read_end  = r_read_end;
  assign io_mem.mem_tag       = r_mem_tag;
  assign io_mem.mem_index     = r_mem_index;
  assign io_mem.mem_readdata  = r_mem_readdata;
  assign io_mem.bus_address   = r_bus_address;
  assign io_mem.bus_read      = r_bus_read;
  assign io_mem.bus_write     = r_bus_write;
  assign io_mem.bus_writedata = r_bus_writedata;

endmodule

// File: tb/tb_cache_mem.sv
// ---------------------------------------------------------------------------
// tb_cache_mem
// Directed bench for cache_mem: reset values, refill, stalled writeback,
// busy rejection, back-to-back, and reset in the middle of a refill.
// ---------------------------------------------------------------------------
module tb_cache_mem;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_mem_if #(.TAG_BITS(16), .INDEX_BITS(12)) mif ();
  logic [1:0] dbg_state;

  cache_mem #(.TAG_BITS(16), .INDEX_BITS(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .io_mem      (mif),
    .o_dbg_state (dbg_state)
  );

  // Bus responder: memory words for the current line, selected by beat
  logic [31:0] rd_words [4];
  assign mif.bus_readdata = rd_words[mif.bus_address[3:2]];

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_wd_q[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every accepted bus beat must match the next expected address (and data for writes)
  always @(negedge clk) begin
    if (rst_n && (mif.bus_read || mif.bus_write) && !mif.bus_waitrequest) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_beat", {96'd0, mif.bus_address}, 128'd0 - 1);
      end else begin
        chk("sb_addr", {96'd0, mif.bus_address}, {96'd0, exp_q.pop_front()});
        if (mif.bus_write) begin
          if (exp_wd_q.size() == 0) chk("sb_extra_wdata", {96'd0, mif.bus_writedata}, 128'd0 - 1);
          else chk("sb_wdata", {96'd0, mif.bus_writedata}, {96'd0, exp_wd_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] tag, input logic [11:0] idx,
                          input logic wb, input logic [127:0] data);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({tag, idx, 4'b0000} | (32'(k) << 2));
      if (wb) exp_wd_q.push_back(data[32*k +: 32]);
    end
  endtask

  task automatic drive_req(input logic wb, input logic [15:0] tag,
                           input logic [11:0] idx, input logic [127:0] data);
    mif.mem_begin = 1'b1;
    mif.writeback = wb;
    mif.req_tag   = tag;
    mif.req_index = idx;
    mif.req_data  = data;
  endtask

  task automatic set_words(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    rd_words[0] = w0; rd_words[1] = w1; rd_words[2] = w2; rd_words[3] = w3;
  endtask

  logic [127:0] wb_line;

  initial begin
    mif.mem_begin       = 1'b1;
    mif.writeback       = 1'b0;
    mif.req_tag         = 16'hFFFF;
    mif.req_index       = 12'hFFF;
    mif.req_data        = '1;
    mif.bus_waitrequest = 1'b0;
    set_words(32'd0, 32'd0, 32'd0, 32'd0);

    // ---- reset values: rst_n low for 2 cycles with mem_begin high ----
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_mem_wait",  {127'd0, mif.mem_wait}, 128'd0);
      chk("rst_mem_end",   {127'd0, mif.mem_end}, 128'd0);
      chk("rst_read_end",  {127'd0, mif.mem_read_end}, 128'd0);
      chk("rst_bus_read",  {127'd0, mif.bus_read}, 128'd0);
      chk("rst_bus_write", {127'd0, mif.bus_write}, 128'd0);
      chk("rst_bus_addr",  {96'd0, mif.bus_address}, 128'd0);
      chk("rst_bus_wdata", {96'd0, mif.bus_writedata}, 128'd0);
      chk("rst_mem_tag",   {112'd0, mif.mem_tag}, 128'd0);
      chk("rst_mem_index", {116'd0, mif.mem_index}, 128'd0);
      chk("rst_readdata",  mif.mem_readdata, 128'd0);
      chk("rst_state",     {126'd0, dbg_state}, 128'd0);
    end
    mif.mem_begin = 1'b0;
    rst_n = 1'b1;
    tick();

    // ---- refill, no stalls ----
    set_words(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    push_exp(16'h1234, 12'h056, 1'b0, '0);
    drive_req(1'b0, 16'h1234, 12'h056, '0);
    tick();                                   // t+1
    mif.mem_begin = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t1_addr",     {96'd0, mif.bus_address}, {96'd0, 32'h12340560 + 32'(4*k)});
      chk("t1_bus_read", {127'd0, mif.bus_read}, 128'd1);
      chk("t1_mem_wait", {127'd0, mif.mem_wait}, 128'd1);
      chk("t1_no_end",   {127'd0, mif.mem_end}, 128'd0);
      tick();
    end                                       // t+5
    chk("t1_mem_end",   {127'd0, mif.mem_end}, 128'd1);
    chk("t1_read_end",  {127'd0, mif.mem_read_end}, 128'd1);
    chk("t1_readdata",  mif.mem_readdata, 128'h000000A3_000000A2_000000A1_000000A0);
    chk("t1_tag",       {112'd0, mif.mem_tag}, 128'h1234);
    chk("t1_index",     {116'd0, mif.mem_index}, 128'h056);
    chk("t1_wait_low",  {127'd0, mif.mem_wait}, 128'd0);
    chk("t1_bus_idle",  {127'd0, mif.bus_read}, 128'd0);
    tick();
    chk("t1_end_pulse", {127'd0, mif.mem_end}, 128'd0);

    // ---- writeback with 3 stall cycles on beat 2 ----
    wb_line = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    push_exp(16'hBEEF, 12'h123, 1'b1, wb_line);
    drive_req(1'b1, 16'hBEEF, 12'h123, wb_line);
    tick();                                   // t+1
    mif.mem_begin = 1'b0;
    mif.writeback = 1'b0;
    chk("t2_addr0",  {96'd0, mif.bus_address}, 128'hBEEF1230);
    chk("t2_wd0",    {96'd0, mif.bus_writedata}, 128'h11111111);
    chk("t2_write",  {127'd0, mif.bus_write}, 128'd1);
    chk("t2_noread", {127'd0, mif.bus_read}, 128'd0);
    tick();                                   // t+2
    chk("t2_addr1",  {96'd0, mif.bus_address}, 128'hBEEF1234);
    chk("t2_wd1",    {96'd0, mif.bus_writedata}, 128'h22222222);
    tick();                                   // t+3: stall begins
    mif.bus_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin         // t+3, t+4, t+5 stalled; t+6 accepted
      chk("t2_addr2_stable", {96'd0, mif.bus_address}, 128'hBEEF1238);
      chk("t2_wd2_stable",   {96'd0, mif.bus_writedata}, 128'h33333333);
      chk("t2_write_held",   {127'd0, mif.bus_write}, 128'd1);
      tick();
    end
    mif.bus_waitrequest = 1'b0;               // t+6
    chk("t2_addr2",  {96'd0, mif.bus_address}, 128'hBEEF1238);
    chk("t2_wd2",    {96'd0, mif.bus_writedata}, 128'h33333333);
    tick();                                   // t+7
    chk("t2_addr3",  {96'd0, mif.bus_address}, 128'hBEEF123C);
    chk("t2_wd3",    {96'd0, mif.bus_writedata}, 128'h44444444);
    chk("t2_no_end_early", {127'd0, mif.mem_end}, 128'd0);
    tick();                                   // t+8
    chk("t2_mem_end",    {127'd0, mif.mem_end}, 128'd1);
    chk("t2_no_readend", {127'd0, mif.mem_read_end}, 128'd0);
    chk("t2_write_off",  {127'd0, mif.bus_write}, 128'd0);
    chk("t2_tag_stable", {112'd0, mif.mem_tag}, 128'h1234);
    chk("t2_line_stable", mif.mem_readdata, 128'h000000A3_000000A2_000000A1_000000A0);
    tick();

    // ---- busy rejection: mem_begin held through the refill ----
    set_words(32'hB0, 32'hB1, 32'hB2, 32'hB3);
    push_exp(16'h00FF, 12'hABC, 1'b0, '0);
    drive_req(1'b0, 16'h00FF, 12'hABC, '0);
    tick();                                   // t+1
    mif.req_tag   = 16'h5555;                 // retries with different contents are ignored
    mif.writeback = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_mem_wait", {127'd0, mif.mem_wait}, 128'd1);
      chk("t3_addr",     {96'd0, mif.bus_address}, {96'd0, 32'h00FFABC0 + 32'(4*k)});
      chk("t3_nowrite",  {127'd0, mif.bus_write}, 128'd0);
      tick();
    end                                       // t+5
    mif.mem_begin = 1'b0;
    mif.writeback = 1'b0;
    chk("t3_mem_end",  {127'd0, mif.mem_end}, 128'd1);
    chk("t3_readdata", mif.mem_readdata, 128'h000000B3_000000B2_000000B1_000000B0);
    chk("t3_tag",      {112'd0, mif.mem_tag}, 128'h00FF);
    chk("t3_index",    {116'd0, mif.mem_index}, 128'hABC);
    tick();
    chk("t3_idle_wait",  {127'd0, mif.mem_wait}, 128'd0);
    chk("t3_idle_read",  {127'd0, mif.bus_read}, 128'd0);
    chk("t3_idle_write", {127'd0, mif.bus_write}, 128'd0);
    chk("t3_one_txn",    128'(exp_q.size()), 128'd0);

    // ---- back-to-back: writeback issued in the refill's mem_end cycle ----
    set_words(32'hC0, 32'hC1, 32'hC2, 32'hC3);
    wb_line = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};
    push_exp(16'h0F0F, 12'h001, 1'b0, '0);
    push_exp(16'h7777, 12'h002, 1'b1, wb_line);
    drive_req(1'b0, 16'h0F0F, 12'h001, '0);
    tick();                                   // t+1
    mif.mem_begin = 1'b0;
    for (int k = 0; k < 4; k++) tick();       // t+5
    chk("t4_mem_end",   {127'd0, mif.mem_end}, 128'd1);
    chk("t4_readdata",  mif.mem_readdata, 128'h000000C3_000000C2_000000C1_000000C0);
    drive_req(1'b1, 16'h7777, 12'h002, wb_line);
    tick();                                   // t+6
    mif.mem_begin = 1'b0;
    mif.writeback = 1'b0;
    chk("t4_bus_write", {127'd0, mif.bus_write}, 128'd1);
    chk("t4_addr0",     {96'd0, mif.bus_address}, 128'h77770020);
    chk("t4_mem_wait",  {127'd0, mif.mem_wait}, 128'd1);
    for (int k = 0; k < 4; k++) tick();       // t+10
    chk("t4_wb_end",      {127'd0, mif.mem_end}, 128'd1);
    chk("t4_wb_readend",  {127'd0, mif.mem_read_end}, 128'd0);
    chk("t4_tag_stable",  {112'd0, mif.mem_tag}, 128'h0F0F);
    tick();

    // ---- reset during beat 2 of a refill ----
    set_words(32'hE0, 32'hE1, 32'hE2, 32'hE3);
    exp_q.push_back(32'h24681350);
    exp_q.push_back(32'h24681354);
    drive_req(1'b0, 16'h2468, 12'h135, '0);
    tick();                                   // t+1
    mif.mem_begin = 1'b0;
    tick();                                   // t+2
    tick();                                   // t+3: beat 2, reset asserted
    rst_n = 1'b0;
    chk("t5_beat2_addr", {96'd0, mif.bus_address}, 128'h24681358);
    chk("t5_beat2_read", {127'd0, mif.bus_read}, 128'd1);
    tick();                                   // t+4
    chk("t5_read_off",  {127'd0, mif.bus_read}, 128'd0);
    chk("t5_wait_off",  {127'd0, mif.mem_wait}, 128'd0);
    chk("t5_no_end",    {127'd0, mif.mem_end}, 128'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_never_end", {127'd0, mif.mem_end}, 128'd0);
    end
    set_words(32'hF0, 32'hF1, 32'hF2, 32'hF3);
    push_exp(16'h1357, 12'h246, 1'b0, '0);
    drive_req(1'b0, 16'h1357, 12'h246, '0);
    tick();                                   // t+1
    mif.mem_begin = 1'b0;
    chk("t5_re_addr0", {96'd0, mif.bus_address}, 128'h13572460);
    for (int k = 0; k < 4; k++) tick();       // t+5
    chk("t5_re_end",      {127'd0, mif.mem_end}, 128'd1);
    chk("t5_re_readend",  {127'd0, mif.mem_read_end}, 128'd1);
    chk("t5_re_readdata", mif.mem_readdata, 128'h000000F3_000000F2_000000F1_000000F0);
    chk("t5_re_tag",      {112'd0, mif.mem_tag}, 128'h1357);
    chk("t5_re_index",    {116'd0, mif.mem_index}, 128'h246);
    tick();

    chk("sb_all_beats_seen", 128'(exp_q.size() + exp_wd_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
